// File: rtl/reg_file_param.sv
// Parametrised dual-read register file with synchronous write, BUSYWAIT-gated commits and a background clear sweep.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic              CLEAR,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              CLR_BUSY,
    output logic              WR_ACK
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [DATA_W-1:0] store [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              commit;
    logic              zero_hit;

    assign commit   = WRITE && !BUSYWAIT && !RESET && (state == IDLE);
    assign zero_hit = (ZERO_REG != 0) && (INADDRESS == '0);
    assign CLR_BUSY = (state == SWEEP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            state  <= IDLE;
            ptr    <= '0;
            WR_ACK <= 1'b0;
        end else begin
            WR_ACK <= commit;
            case (state)
                IDLE: begin
                    // Address-0 writes are dropped when hardwired to zero, but still acknowledged
                    if (commit && !zero_hit) begin
                        store[INADDRESS] <= IN;
                    end
                    if (CLEAR) begin
                        state <= SWEEP;
                        ptr   <= '0;
                    end
                end
                SWEEP: begin
                    store[ptr] <= '0;
                    ptr        <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        OUT1 = store[OUT1ADDRESS];
`ifdef REGFILE_BYPASS_EN
        if (commit && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end
`endif
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
    end

    always_comb begin
        OUT2 = store[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
        if (commit && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end
`endif
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share the stimulus: default (ZERO_REG=0) and ZERO_REG=1.
module tb_reg_file_param;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] wa = '0;
    logic       write = 1'b0;
    logic       busywait = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] rd1 = '0;
    logic [2:0] rd2 = '0;

    logic [7:0] o1, o2, z1, z2;
    logic       busy, ack, zbusy, zack;

    int tests = 0;
    int fails = 0;

    // Behavioural model: contents, remaining sweep cycles, next entry to clear, expected ack
    logic [7:0] m [8];
    int         sw_left = 0;
    int         sw_idx = 0;
    logic       m_ack = 1'b0;

    always #5 CLK = ~CLK;

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
        .CLK(CLK), .RESET(RESET), .IN(din), .INADDRESS(wa), .WRITE(write),
        .BUSYWAIT(busywait), .CLEAR(clear), .OUT1ADDRESS(rd1), .OUT2ADDRESS(rd2),
        .OUT1(o1), .OUT2(o2), .CLR_BUSY(busy), .WR_ACK(ack)
    );

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .RESET(RESET), .IN(din), .INADDRESS(wa), .WRITE(write),
        .BUSYWAIT(busywait), .CLEAR(clear), .OUT1ADDRESS(rd1), .OUT2ADDRESS(rd2),
        .OUT1(z1), .OUT2(z2), .CLR_BUSY(zbusy), .WR_ACK(zack)
    );

    function automatic bit bypass_on();
`ifdef REGFILE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit commit_now();
        return write && !busywait && !RESET && (sw_left == 0);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [2:0] a, input bit zero);
        if (zero && a == 3'd0) return 8'h00;
        if (bypass_on() && commit_now() && a == wa) return din;
        return m[a];
    endfunction

    task automatic model_step();
        if (RESET) begin
            for (int i = 0; i < 8; i++) m[i] = 8'h00;
            sw_left = 0;
            sw_idx  = 0;
            m_ack   = 1'b0;
        end else begin
            m_ack = commit_now();
            if (sw_left > 0) begin
                m[sw_idx] = 8'h00;
                sw_idx++;
                sw_left--;
            end else begin
                if (m_ack) m[wa] = din;
                if (clear) begin
                    sw_left = 8;
                    sw_idx  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd1 = 3'(i);
            rd2 = 3'(7 - i);
            #1;
            tests++;
            if (o1 !== 8'h00 || o2 !== 8'h00) begin
                fails++;
                $display("FAIL reset_read[%0d]: got %h/%h want 00/00", i, o1, o2);
            end
        end
        tests++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b ack=%b want 0/0", busy, ack);
        end
    endtask

    task automatic test_writes();
        write = 1'b1; wa = 3'd3; din = 8'hA5;
        tick();
        tests++;
        if (ack !== 1'b1) begin
            fails++;
            $display("FAIL write_ack1: got %b want 1", ack);
        end
        wa = 3'd7; din = 8'h3C;
        tick();
        write = 1'b0;
        rd1 = 3'd3; rd2 = 3'd7;
        #1;
        tests++;
        if (ack !== 1'b1 || o1 !== 8'hA5 || o2 !== 8'h3C) begin
            fails++;
            $display("FAIL write_read: ack=%b out1=%h out2=%h want 1/a5/3c", ack, o1, o2);
        end
        tick();
        tests++;
        if (ack !== 1'b0) begin
            fails++;
            $display("FAIL write_ack_drop: got %b want 0", ack);
        end
    endtask

    task automatic test_busywait();
        logic [7:0] want;
        write = 1'b1; wa = 3'd2; din = 8'h11; busywait = 1'b1; rd1 = 3'd2;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (ack !== 1'b0 || o1 !== 8'h00) begin
                fails++;
                $display("FAIL busywait_stall[%0d]: ack=%b out1=%h want 0/00", c, ack, o1);
            end
        end
        busywait = 1'b0;
        #1;
        want = bypass_on() ? 8'h11 : 8'h00;
        tests++;
        if (o1 !== want) begin
            fails++;
            $display("FAIL busywait_release_same_cycle: got %h want %h", o1, want);
        end
        tick();
        write = 1'b0;
        #1;
        tests++;
        if (o1 !== 8'h11 || ack !== 1'b1) begin
            fails++;
            $display("FAIL busywait_commit: out1=%h ack=%b want 11/1", o1, ack);
        end
        tick();
        tests++;
        if (ack !== 1'b0) begin
            fails++;
            $display("FAIL busywait_single_ack: got %b want 0", ack);
        end
    endtask

    task automatic test_clear_sweep();
        int n;
        write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wa = 3'(i); din = 8'(i + 1);
            tick();
        end
        write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd1 = 3'(i);
            #1;
            tests++;
            if (o1 !== 8'(i + 1)) begin
                fails++;
                $display("FAIL fill_read[%0d]: got %h want %h", i, o1, 8'(i + 1));
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        write = 1'b1; wa = 3'd5; din = 8'hFF; rd2 = 3'd5;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            rd1 = 3'(n % 8);
            clear = (n == 3);
            #1;
            tests++;
            if (ack !== 1'b0 || o1 !== exp_rd(rd1, 1'b0) || o2 !== exp_rd(rd2, 1'b0)) begin
                fails++;
                $display("FAIL sweep_cycle[%0d]: ack=%b out1=%h out2=%h want 0/%h/%h",
                         n, ack, o1, o2, exp_rd(rd1, 1'b0), exp_rd(rd2, 1'b0));
            end
            n++;
            tick();
        end
        write = 1'b0; clear = 1'b0;
        tests++;
        if (n !== 8) begin
            fails++;
            $display("FAIL sweep_length: got %0d cycles want 8", n);
        end
        for (int i = 0; i < 8; i++) begin
            rd1 = 3'(i);
            #1;
            tests++;
            if (o1 !== 8'h00) begin
                fails++;
                $display("FAIL sweep_cleared[%0d]: got %h want 00", i, o1);
            end
        end
        tests++;
        if (ack !== 1'b0) begin
            fails++;
            $display("FAIL sweep_no_ack: got %b want 0", ack);
        end
    endtask

    task automatic test_reset_mid_sweep();
        write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wa = 3'(i); din = 8'($urandom_range(1, 255));
            tick();
        end
        write = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        RESET = 1'b1; clear = 1'b1; write = 1'b1; wa = 3'd6; din = 8'h99;
        tick();
        RESET = 1'b0; clear = 1'b0; write = 1'b0;
        tests++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            fails++;
            $display("FAIL midsweep_reset_flags: busy=%b ack=%b want 0/0", busy, ack);
        end
        for (int i = 0; i < 8; i++) begin
            rd1 = 3'(i);
            #1;
            tests++;
            if (o1 !== 8'h00) begin
                fails++;
                $display("FAIL midsweep_reset_read[%0d]: got %h want 00", i, o1);
            end
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL midsweep_no_restart: busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_reg();
        write = 1'b1; wa = 3'd0; din = 8'h77;
        tick();
        write = 1'b0; rd1 = 3'd0;
        #1;
        tests++;
        if (z1 !== 8'h00 || zack !== 1'b1) begin
            fails++;
            $display("FAIL zero_reg: out1=%h ack=%b want 00/1", z1, zack);
        end
        tests++;
        if (o1 !== 8'h77) begin
            fails++;
            $display("FAIL zero_reg_off: out1=%h want 77", o1);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] want;
        write = 1'b1; wa = 3'd4; din = 8'h33;
        tick();
        din = 8'h5A; rd2 = 3'd4;
        #1;
        want = bypass_on() ? 8'h5A : 8'h33;
        tests++;
        if (o2 !== want) begin
            fails++;
            $display("FAIL bypass_same_cycle: got %h want %h", o2, want);
        end
        tick();
        write = 1'b0;
        #1;
        tests++;
        if (o2 !== 8'h5A) begin
            fails++;
            $display("FAIL bypass_after_edge: got %h want 5a", o2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RESET    = ($urandom_range(0, 99) < 2);
            write    = ($urandom_range(0, 99) < 60);
            busywait = ($urandom_range(0, 99) < 30);
            clear    = ($urandom_range(0, 99) < 4);
            wa  = 3'($urandom);
            din = 8'($urandom);
            rd1 = 3'($urandom);
            rd2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
            #1;
            tests++;
            if (o1 !== exp_rd(rd1, 1'b0) || o2 !== exp_rd(rd2, 1'b0) ||
                z1 !== exp_rd(rd1, 1'b1) || z2 !== exp_rd(rd2, 1'b1)) begin
                fails++;
                $display("FAIL random_read[%0d]: got %h %h %h %h want %h %h %h %h", c, o1, o2, z1, z2,
                         exp_rd(rd1, 1'b0), exp_rd(rd2, 1'b0), exp_rd(rd1, 1'b1), exp_rd(rd2, 1'b1));
            end
            tests++;
            if (busy !== (sw_left > 0) || zbusy !== (sw_left > 0) || ack !== m_ack || zack !== m_ack) begin
                fails++;
                $display("FAIL random_flags[%0d]: busy=%b/%b ack=%b/%b want %b/%b", c, busy, zbusy,
                         ack, zack, (sw_left > 0), m_ack);
            end
            tick();
        end
        RESET = 1'b0; write = 1'b0; busywait = 1'b0; clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        @(posedge CLK);
        #1;
        test_reset();
        test_writes();
        test_busywait();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_zero_reg();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised, synchronous-write, dual-read-port register file for the 8-bit CPU datapath, and the successor to the fixed 8×8 register file.

- Word width and depth are configurable.
- An optional hardwired-zero register is supported.
- A background clear sequencer zeroes the file one entry per cycle without a full reset.
- Writes are gated by the memory subsystem's BUSYWAIT stall.
- An optional write-to-read bypass is provided.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high; clock CLK
- IN  input  DATA_W  write data
- INADDRESS  input  ADDR_W  write address
- WRITE  input  1  write request
- BUSYWAIT  input  1  memory stall; blocks writes while high
- CLEAR  input  1  start background clear sweep
- OUT1ADDRESS, OUT2ADDRESS  input  ADDR_W  read addresses
- OUT1, OUT2  output  DATA_W  read data, combinational from store
- CLR_BUSY  output  1  high while a clear sweep runs
- WR_ACK  output  1  registered; high for one cycle after a committed write

## Operation
- **Storage:** DEPTH × DATA_W array. Reads are combinational and zero-delay: OUTn = store[OUTnADDRESS]. With ZERO_REG=1, address 0 reads 0.
- **Write commit condition:** a write commits at a rising edge when WRITE && !BUSYWAIT && !RESET && state==IDLE.
  - On commit, store[INADDRESS] <= IN.
  - On commit, WR_ACK <= 1; otherwise WR_ACK <= 0.
  - With ZERO_REG=1, a write to address 0 is dropped, but WR_ACK still pulses.
- **FSM states:** IDLE and SWEEP. A 2-state FSM plus an ADDR_W-bit pointer ptr.
  - IDLE: CLEAR && !RESET → SWEEP, ptr <= 0.
  - SWEEP: each edge does store[ptr] <= 0 and ptr <= ptr+1. When ptr == DEPTH-1, the clear of that entry is also the transition → IDLE.
  - CLR_BUSY = (state==SWEEP), decoded from the state register.
  - CLEAR asserted while in SWEEP is ignored; it does not restart the sweep.
  - A sweep takes exactly DEPTH cycles.
- **Writes during SWEEP:** dropped, with no WR_ACK. The CPU control must hold WRITE until CLR_BUSY falls.
- **Reads during SWEEP:** return current contents. Entries already cleared read 0; entries not yet cleared keep their values.
- **RESET:** at the edge where RESET=1, all entries <= 0, state <= IDLE, ptr <= 0, WR_ACK <= 0. RESET has priority over WRITE and CLEAR in the same cycle, and over a sweep in progress.
- **Reset values:** OUT1 = OUT2 = 0 (store cleared), CLR_BUSY = 0, WR_ACK = 0.
- **Undefined addresses:** none exist; all ADDR_W values map to entries.

## Timing
- **Write latency:** a committed write is visible on OUTn after the commit edge, i.e. from the next cycle (without bypass).
- **WR_ACK:** high exactly in the cycle following the commit edge. Back-to-back commits keep it high continuously.
- **BUSYWAIT:** sampled at the edge only. BUSYWAIT high at the edge blocks the write, even if it falls mid-cycle.
- **CLEAR at cycle 0:** CLR_BUSY is high during cycles 1..DEPTH and low in cycle DEPTH+1. The first cycle a write can commit is the edge ending cycle DEPTH+1.
- **Same-address conflict:** read and write to the same address in one cycle returns old data unless bypass is compiled in.

## Configuration
- **REGFILE_BYPASS_EN defined:**
  - When the write commit condition holds combinationally and OUTnADDRESS == INADDRESS, OUTn = IN in the same cycle.
  - The ZERO_REG rule overrides the bypass for address 0.
- **REGFILE_BYPASS_EN undefined:** reads always return stored contents.

## Test plan
- **Reset then writes:** RESET 1 cycle, then write 8'hA5→r3 and 8'h3C→r7. Required: OUT1ADDRESS=3 → A5 and OUT2ADDRESS=7 → 3C from the next cycle; WR_ACK pulses twice.
- **BUSYWAIT stall:** BUSYWAIT=1 with WRITE 8'h11→r2 for 3 cycles, then BUSYWAIT=0. Required: r2 stays 0 until one edge after BUSYWAIT falls, then reads 11; a single WR_ACK pulse.
- **Clear sweep:** fill r0..r7 with 1..8, pulse CLEAR, WRITE 8'hFF→r5 during the sweep. Required: CLR_BUSY high for exactly 8 cycles; r5 becomes 0, not FF; no WR_ACK; all entries 0 afterwards.
- **Reset mid-sweep:** RESET at sweep cycle 3 while CLEAR is asserted. Required: all entries 0, CLR_BUSY 0 in the next cycle, no new sweep starts.
- **ZERO_REG=1:** write 8'h77→r0. Required: OUT1 reads 0 and WR_ACK pulses.
- **Bypass:** with REGFILE_BYPASS_EN, write 8'h5A→r4 while OUT2ADDRESS=4. Required: OUT2=5A in the same cycle. Without the macro, OUT2 shows the old value until the edge.
